// File: rtl/bit_entry_pkg.sv
// Shared types and constants for the bit entry front end.
// The step FSM state encoding and the synchronizer depth live here.
package bit_entry_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FIRE,
      S_HELD
   } step_state_t;

   localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/bit_entry_conditioner_debounce_filter.sv
// Synchronizes one raw asynchronous input and accepts a level change only
// after it has been seen on DEBOUNCE_CYCLES consecutive cycles.
module debounce_filter
   import bit_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CW-1:0]          cnt_reg;
   logic                   deb_reg;
   logic                   synced;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (!rst) sync_reg[gi] <= 1'b0;
               else      sync_reg[gi] <= raw;
            end
         end else begin : g_rest
            always_ff @(posedge clk) begin
               if (!rst) sync_reg[gi] <= 1'b0;
               else      sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign synced = sync_reg[SYNC_STAGES-1];

   // Any cycle that agrees with the accepted level restarts the stability count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
         deb_reg <= 1'b0;
      end else if (synced == deb_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
         cnt_reg <= '0;
         deb_reg <= synced;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign deb = deb_reg;

endmodule

// File: rtl/bit_entry_conditioner.sv
// Turns a debounced step button into one ena strobe per press, capturing the
// debounced data switch into sig_to_test and counting entered bits.
module bit_entry_conditioner
   import bit_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sw_data,
   input  logic             btn_step,
   output logic             sig_to_test,
   output logic             ena,
   output logic [CNT_W-1:0] entry_count
);

   logic        deb_data;
   logic        deb_btn;
   step_state_t state_reg;
   step_state_t state_next;
   logic        sig_reg;
   logic [CNT_W-1:0] count_reg;

   debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_data (
      .clk (clk),
      .rst (rst),
      .raw (sw_data),
      .deb (deb_data)
   );

   debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_btn (
      .clk (clk),
      .rst (rst),
      .raw (btn_step),
      .deb (deb_btn)
   );

   always_ff @(posedge clk) begin
      if (!rst) state_reg <= S_IDLE;
      else      state_reg <= state_next;
   end

   // Holding the button parks in S_HELD, so a long press yields a single bit.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (deb_btn) state_next = S_FIRE;
         S_FIRE:  state_next = deb_btn ? S_HELD : S_IDLE;
         S_HELD:  if (!deb_btn) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sig_reg   <= 1'b0;
         count_reg <= '0;
      end else if (state_next == S_FIRE) begin
         sig_reg   <= deb_data;
         count_reg <= count_reg + 1'b1;
      end
   end

   assign ena         = (state_reg == S_FIRE);
   assign sig_to_test = sig_reg;
   assign entry_count = count_reg;

endmodule

// File: tb/tb_bit_entry_conditioner.sv
// Directed bench for bit_entry_conditioner with DEBOUNCE_CYCLES = 4.
// Counts ena strobes per phase and checks timing, captured bit and count.
module tb_bit_entry_conditioner;

   localparam int DC    = 4;
   localparam int CNT_W = 8;
   localparam int LAT   = DC + 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             sw_data = 1'b0;
   logic             btn_step = 1'b0;
   logic             sig_to_test;
   logic             ena;
   logic [CNT_W-1:0] entry_count;

   int n_cmp = 0;
   int n_err = 0;

   int tick_idx   = 0;
   int pulses     = 0;
   int first_idx  = -1;
   logic pulse_sig = 1'b0;

   bit_entry_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .sw_data     (sw_data),
      .btn_step    (btn_step),
      .sig_to_test (sig_to_test),
      .ena         (ena),
      .entry_count (entry_count)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // One clock edge, then sample outputs and log any strobe.
   task automatic step();
      @(posedge clk);
      #1;
      if (ena === 1'b1) begin
         if (first_idx < 0) first_idx = tick_idx;
         pulses++;
         pulse_sig = sig_to_test;
      end
      tick_idx++;
   endtask

   task automatic clear_mon();
      tick_idx  = 0;
      pulses    = 0;
      first_idx = -1;
   endtask

   task automatic do_reset();
      btn_step = 1'b0;
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 2 * DC + 4; i++) step();
   endtask

   // Full press and release with the data switch set alongside the button.
   task automatic press(input logic bit_val);
      sw_data  = bit_val;
      btn_step = 1'b1;
      for (int i = 0; i < LAT + 4; i++) step();
      btn_step = 1'b0;
      for (int i = 0; i < LAT + 4; i++) step();
   endtask

   logic [7:0] seq_bits;

   initial begin
      // Reset held 3 cycles while raw inputs toggle.
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sw_data  = i[0];
         btn_step = ~i[0];
         step();
         check_val($sformatf("rst_ena_%0d", i), {31'd0, ena}, 32'd0);
         check_val($sformatf("rst_sig_%0d", i), {31'd0, sig_to_test}, 32'd0);
         check_val($sformatf("rst_cnt_%0d", i), {24'd0, entry_count}, 32'd0);
      end
      sw_data  = 1'b0;
      btn_step = 1'b0;
      rst = 1'b1;
      step();
      check_val("post_rst_ena", {31'd0, ena}, 32'd0);
      check_val("post_rst_sig", {31'd0, sig_to_test}, 32'd0);
      check_val("post_rst_cnt", {24'd0, entry_count}, 32'd0);
      for (int i = 0; i < 4; i++) step();

      // Clean press with data set beforehand.
      sw_data = 1'b1;
      step(); step();
      clear_mon();
      btn_step = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check_val("clean_pulses", pulses, 32'd1);
      check_val("clean_latency", first_idx, LAT);
      check_val("clean_sig", {31'd0, pulse_sig}, 32'd1);
      check_val("clean_cnt", {24'd0, entry_count}, 32'd1);

      // Data change debounced while held must not reach sig_to_test.
      sw_data = 1'b0;
      clear_mon();
      for (int i = 0; i < 12; i++) step();
      check_val("held_pulses", pulses, 32'd0);
      check_val("held_sig", {31'd0, sig_to_test}, 32'd1);

      btn_step = 1'b0;
      for (int i = 0; i < 12; i++) step();
      check_val("release_pulses", pulses, 32'd0);

      // Press bounce: 2-cycle segments never qualify; timing from final rise.
      sw_data = 1'b1;
      clear_mon();
      for (int i = 0; i < 12; i++) begin
         btn_step = ((i / 2) % 2 == 0);
         step();
      end
      btn_step = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check_val("bounce_pulses", pulses, 32'd1);
      check_val("bounce_latency", first_idx - 12, LAT);
      check_val("bounce_cnt", {24'd0, entry_count}, 32'd2);

      // Release bounce produces nothing.
      clear_mon();
      for (int i = 0; i < 12; i++) begin
         btn_step = ((i / 2) % 2 == 1);
         step();
      end
      btn_step = 1'b0;
      for (int i = 0; i < 12; i++) step();
      check_val("rel_bounce_pulses", pulses, 32'd0);
      check_val("rel_bounce_cnt", {24'd0, entry_count}, 32'd2);

      // Sequence entry 0,1,0,0,1,0,1,1 from a fresh reset.
      do_reset();
      check_val("seq_start_cnt", {24'd0, entry_count}, 32'd0);
      seq_bits = 8'b1101_0010;
      for (int k = 0; k < 8; k++) begin
         clear_mon();
         press(seq_bits[k]);
         check_val($sformatf("seq_pulses_%0d", k), pulses, 32'd1);
         check_val($sformatf("seq_bit_%0d", k), {31'd0, pulse_sig}, {31'd0, seq_bits[k]});
      end
      check_val("seq_cnt", {24'd0, entry_count}, 32'd8);

      // 256 presses wrap the count back to 0.
      do_reset();
      clear_mon();
      for (int k = 0; k < 255; k++) press(k[0]);
      check_val("wrap_cnt_255", {24'd0, entry_count}, 32'd255);
      press(1'b1);
      check_val("wrap_pulses", pulses, 32'd256);
      check_val("wrap_cnt_0", {24'd0, entry_count}, 32'd0);

      // Reset inside the debounce window cancels the press.
      press(1'b1);
      check_val("pre_midrst_cnt", {24'd0, entry_count}, 32'd1);
      clear_mon();
      sw_data  = 1'b1;
      btn_step = 1'b1;
      for (int i = 0; i < 3; i++) step();
      rst = 1'b0;
      step();
      check_val("midrst_ena", {31'd0, ena}, 32'd0);
      check_val("midrst_cnt", {24'd0, entry_count}, 32'd0);
      check_val("midrst_pulses", pulses, 32'd0);
      rst = 1'b1;
      clear_mon();
      for (int i = 0; i < 20; i++) step();
      check_val("after_rst_pulses", pulses, 32'd1);
      check_val("after_rst_latency", first_idx, LAT);
      check_val("after_rst_cnt", {24'd0, entry_count}, 32'd1);
      check_val("after_rst_sig", {31'd0, pulse_sig}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
